// File: rtl/width_converter_8ton.sv
// Receive-path 8-to-N bit width converter: packs bytes LSB-first into Width-bit words.
// Latency: word valid one cycle after its last byte (or flush); Bytes bytes per Bytes+1 cycles.
// Backpressure: accumulator keeps filling while the output stalls; sink_ready_o drops once it is closed.
//
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   sink_valid_i/sink_ready_o/sink_data_i  byte stream from the target FSM
//   sink_flush_i                       end-of-transfer pulse, closes a partial word
//   clear_i                            synchronous abort, drops all buffered data
//   source_valid_o/source_ready_i      word handshake toward the RX queue
//   source_data_o, source_bcnt_o       packed word and its count of valid bytes (1..Bytes)
module width_converter_8ton #(
  parameter int Width = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        sink_valid_i,
  output logic                        sink_ready_o,
  input  logic [7:0]                  sink_data_i,
  input  logic                        sink_flush_i,
  input  logic                        clear_i,
  output logic                        source_valid_o,
  input  logic                        source_ready_i,
  output logic [Width-1:0]            source_data_o,
  output logic [$clog2(Width/8):0]    source_bcnt_o
);

  localparam int Bytes = Width / 8;
  localparam int BcntW = $clog2(Bytes) + 1;

  if ((Width % 8) != 0 || Width < 8) begin : g_bad_width
    $error("width_converter_8ton: Width must be a multiple of 8 and >= 8");
  end

  // Accumulator stage
  logic [Width-1:0] acc_q, acc_d;
  logic [BcntW-1:0] bcnt_q, bcnt_d;
  logic             flush_pend_q, flush_pend_d;

  // Output stage
  logic [Width-1:0] out_data_q, out_data_d;
  logic [BcntW-1:0] out_bcnt_q, out_bcnt_d;
  logic             out_valid_q, out_valid_d;

  logic             closed;
  logic             byte_hs;
  logic             xfer;
  logic [Width-1:0] acc_masked;

  assign closed       = (bcnt_q == BcntW'(Bytes)) || flush_pend_q;
  assign sink_ready_o = !closed && !clear_i;
  assign byte_hs      = sink_valid_i && sink_ready_o;
  assign xfer         = closed && (!out_valid_q || source_ready_i);

  // Unfilled upper bytes are zero by construction, masking keeps that explicit.
  always_comb begin
    acc_masked = '0;
    for (int i = 0; i < Bytes; i++) begin
      if (BcntW'(i) < bcnt_q) begin
        acc_masked[8*i +: 8] = acc_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    acc_d        = acc_q;
    bcnt_d       = bcnt_q;
    flush_pend_d = flush_pend_q;
    if (clear_i || xfer) begin
      acc_d        = '0;
      bcnt_d       = '0;
      flush_pend_d = 1'b0;
    end else begin
      if (byte_hs) begin
        for (int i = 0; i < Bytes; i++) begin
          if (bcnt_q == BcntW'(i)) begin
            acc_d[8*i +: 8] = sink_data_i;
          end
        end
        bcnt_d = bcnt_q + BcntW'(1);
      end
      // A flush only closes a word that will hold at least one byte; a flush
      // arriving while already closed is dropped.
      if (sink_flush_i && !closed && (bcnt_d != '0)) begin
        flush_pend_d = 1'b1;
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_bcnt_d  = out_bcnt_q;
    out_valid_d = out_valid_q;
    if (clear_i) begin
      out_data_d  = '0;
      out_bcnt_d  = '0;
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_data_d  = acc_masked;
      out_bcnt_d  = bcnt_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && source_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q        <= '0;
      bcnt_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      bcnt_q       <= bcnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data_q  <= '0;
      out_bcnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_bcnt_q  <= out_bcnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign source_valid_o = out_valid_q;
  assign source_data_o  = out_data_q;
  assign source_bcnt_o  = out_bcnt_q;

endmodule

// File: tb/tb_width_converter_8ton.sv
// Self-checking bench for width_converter_8ton (Width=32).
// Directed scenarios followed by randomized traffic against a byte-queue reference model.
// Words are predicted from the accepted byte stream, flushes and clears only.
module tb_width_converter_8ton;

  localparam int Width = 32;
  localparam int Bytes = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        sink_valid_i;
  logic        sink_ready_o;
  logic [7:0]  sink_data_i;
  logic        sink_flush_i;
  logic        clear_i;
  logic        source_valid_o;
  logic        source_ready_i;
  logic [31:0] source_data_o;
  logic [2:0]  source_bcnt_o;

  width_converter_8ton #(.Width(Width)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .sink_valid_i   (sink_valid_i),
    .sink_ready_o   (sink_ready_o),
    .sink_data_i    (sink_data_i),
    .sink_flush_i   (sink_flush_i),
    .clear_i        (clear_i),
    .source_valid_o (source_valid_o),
    .source_ready_i (source_ready_i),
    .source_data_o  (source_data_o),
    .source_bcnt_o  (source_bcnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    int          bcnt;
  } word_t;

  word_t       exp_q[$];
  logic [7:0]  cur_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        last_acc;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic [2:0]  prev_bcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Close the bytes collected so far into an expected word, byte i at bits [8i+7:8i].
  function automatic void push_word();
    word_t w;
    w.data = '0;
    w.bcnt = cur_q.size();
    foreach (cur_q[i]) w.data = w.data | (32'(cur_q[i]) << (8 * i));
    exp_q.push_back(w);
    cur_q.delete();
  endfunction

  function automatic void model_reset();
    cur_q.delete();
    exp_q.delete();
    prev_stall = 1'b0;
  endfunction

  // One clock: drive at the falling edge, sample before the rising edge, update the model.
  task automatic cycle(input logic v, input logic [7:0] d, input logic fl,
                       input logic clr, input logic sr);
    logic  src_hs;
    word_t w;
    sink_valid_i   = v;
    sink_data_i    = d;
    sink_flush_i   = fl;
    clear_i        = clr;
    source_ready_i = sr;
    #2;
    if (prev_stall) begin
      chk("stall_valid", 32'(source_valid_o), 32'd1);
      chk("stall_data", source_data_o, prev_data);
      chk("stall_bcnt", 32'(source_bcnt_o), 32'(prev_bcnt));
    end
    last_acc = v && sink_ready_o;
    src_hs   = source_valid_o && sr;
    if (src_hs) begin
      chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("word_data", source_data_o, w.data);
        chk("word_bcnt", 32'(source_bcnt_o), 32'(w.bcnt));
      end
    end
    prev_stall = source_valid_o && !sr && !clr;
    prev_data  = source_data_o;
    prev_bcnt  = source_bcnt_o;
    if (clr) begin
      cur_q.delete();
      exp_q.delete();
    end else begin
      if (last_acc) begin
        cur_q.push_back(d);
        if (cur_q.size() == Bytes) push_word();
      end
      if (fl && cur_q.size() > 0) push_word();
    end
    @(negedge clk_i);
  endtask

  task automatic send(input logic [7:0] d, input logic fl, input logic sr);
    int n;
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 20) begin
      cycle(1'b1, d, fl, 1'b0, sr);
      n++;
    end
    chk("send_accepted", 32'(last_acc), 32'd1);
  endtask

  task automatic idle(input int n, input logic sr);
    repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b0, sr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i          = 1'b1;
    sink_valid_i   = 1'b0;
    sink_data_i    = 8'h00;
    sink_flush_i   = 1'b0;
    clear_i        = 1'b0;
    source_ready_i = 1'b0;
    last_acc       = 1'b0;
    prev_stall     = 1'b0;
    prev_data      = '0;
    prev_bcnt      = '0;
    #1;
    chk("rst_ready", 32'(sink_ready_o), 32'd1);
    chk("rst_valid", 32'(source_valid_o), 32'd0);
    chk("rst_data", source_data_o, 32'd0);
    chk("rst_bcnt", 32'(source_bcnt_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Full word back-to-back, latency and single-cycle valid
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    send(8'h33, 1'b0, 1'b1);
    send(8'h44, 1'b0, 1'b1);
    chk("full_valid_at_k", 32'(source_valid_o), 32'd0);
    chk("full_closed_ready", 32'(sink_ready_o), 32'd0);
    idle(1, 1'b1);
    chk("full_valid_k1", 32'(source_valid_o), 32'd1);
    chk("full_data", source_data_o, 32'h44332211);
    chk("full_bcnt", 32'(source_bcnt_o), 32'd4);
    idle(1, 1'b1);
    chk("full_one_cycle", 32'(source_valid_o), 32'd0);

    // Flush together with the second byte
    send(8'hAA, 1'b0, 1'b1);
    send(8'hBB, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("flush_valid", 32'(source_valid_o), 32'd1);
    chk("flush_data", source_data_o, 32'h0000BBAA);
    chk("flush_bcnt", 32'(source_bcnt_o), 32'd2);
    send(8'h01, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(1, 1'b1);
    chk("fresh_data", source_data_o, 32'h00000001);
    chk("fresh_bcnt", 32'(source_bcnt_o), 32'd1);
    idle(2, 1'b1);

    // Flush on an empty accumulator is ignored
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("empty_flush_valid", 32'(source_valid_o), 32'd0);
      chk("empty_flush_ready", 32'(sink_ready_o), 32'd1);
    end

    // Backpressure: two words buffered, order preserved
    for (int b = 1; b <= 8; b++) send(8'(b), 1'b0, 1'b0);
    chk("bp_ready", 32'(sink_ready_o), 32'd0);
    chk("bp_valid", 32'(source_valid_o), 32'd1);
    chk("bp_data", source_data_o, 32'h04030201);
    chk("bp_bcnt", 32'(source_bcnt_o), 32'd4);
    idle(5, 1'b0);
    idle(1, 1'b1);
    chk("bp_second", source_data_o, 32'h08070605);
    idle(3, 1'b1);

    // Clear drops a partial word and blocks a same-cycle byte
    send(8'h10, 1'b0, 1'b1);
    send(8'h20, 1'b0, 1'b1);
    send(8'h30, 1'b0, 1'b1);
    cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
    chk("clear_blocks_byte", 32'(last_acc), 32'd0);
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b1);
      chk("clear_no_word", 32'(source_valid_o), 32'd0);
    end
    for (int b = 0; b < 4; b++) send(8'hA0 + 8'(b), 1'b0, 1'b1);
    idle(1, 1'b1);
    chk("after_clear_valid", 32'(source_valid_o), 32'd1);
    chk("after_clear_data", source_data_o, 32'hA3A2A1A0);
    idle(2, 1'b1);

    // Asynchronous reset mid-word and mid-stall
    for (int b = 0; b < 4; b++) send(8'h61 + 8'(b), 1'b0, 1'b0);
    idle(1, 1'b0);
    send(8'h71, 1'b0, 1'b0);
    send(8'h72, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(source_valid_o), 32'd1);
    #3;
    rst_i = 1'b1;
    #1;
    chk("arst_ready", 32'(sink_ready_o), 32'd1);
    chk("arst_valid", 32'(source_valid_o), 32'd0);
    chk("arst_data", source_data_o, 32'd0);
    chk("arst_bcnt", 32'(source_bcnt_o), 32'd0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle(1, 1'b1);
      chk("post_rst_no_word", 32'(source_valid_o), 32'd0);
    end

    // Randomized traffic
    repeat (3000) begin
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(10, 1'b1);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
